// File: rtl/dump_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// dump_rd_ctrl_if
// Bundles the signals between the dump read controller and its neighbours:
// the command processor (strt_rd), the capture controller (ram_addr), the UART
// response path (resp_sent) and the shared channel-RAM read port.
//
//   strt_rd    1       one-cycle request to start a dump
//   ram_addr   LOG2    last valid address written by capture control
//   resp_sent  1       current byte has been transmitted to host
//   rd_addr    LOG2    shared read address to all channel RAMs
//   rd_en      1       RAM read enable, one cycle per fetch
//   data_vld   1       RAM read data valid and held for transmission
//   rd_done    1       all bytes of the dump sent (level)
//   busy       1       dump in progress
//   byte_cnt   LOG2+1  bytes sent so far in the current dump
//
// master: the read controller.  slave: the surrounding system.
// -----------------------------------------------------------------------------
interface dump_rd_ctrl_if #(
    parameter int LOG2 = 9
);
    logic            strt_rd;
    logic [LOG2-1:0] ram_addr;
    logic            resp_sent;
    logic [LOG2-1:0] rd_addr;
    logic            rd_en;
    logic            data_vld;
    logic            rd_done;
    logic            busy;
    logic [LOG2:0]   byte_cnt;

    modport master (
        input  strt_rd, ram_addr, resp_sent,
        output rd_addr, rd_en, data_vld, rd_done, busy, byte_cnt
    );

    modport slave (
        output strt_rd, ram_addr, resp_sent,
        input  rd_addr, rd_en, data_vld, rd_done, busy, byte_cnt
    );
endinterface

// File: rtl/dump_rd_ctrl.sv
// -----------------------------------------------------------------------------
// dump_rd_ctrl
// Sequences the read-out of the channel sample RAMs for a dump command. On a
// start request it walks all ENTRIES locations oldest-first, beginning one past
// the last address written by capture control and wrapping at ENTRIES. Each
// byte is fetched (rd_en), given one cycle of RAM latency, then presented with
// data_vld until the UART path reports resp_sent. rd_done is raised once the
// last byte has gone out and stays up until the next start.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   dump_rd_ctrl_if.master (strt_rd, ram_addr, resp_sent in;
//         rd_addr, rd_en, data_vld, rd_done, busy, byte_cnt out)
// -----------------------------------------------------------------------------
module dump_rd_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic           clk,
    input  logic           rst,
    dump_rd_ctrl_if.master bus
);

    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   CNT_FULL  = (LOG2 + 1)'(ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAT,
        PRESENT,
        DONE
    } state_t;

    state_t          state_q,    state_d;
    logic [LOG2-1:0] rd_addr_q,  rd_addr_d;
    logic [LOG2:0]   byte_cnt_q, byte_cnt_d;
    logic            rd_done_q,  rd_done_d;

    // Successor address with wrap. Using >= rather than == also folds any
    // out-of-range ram_addr onto 0, so ENTRIES need not be a power of two and
    // the address can never leave [0, ENTRIES-1].
    function automatic logic [LOG2-1:0] next_addr(input logic [LOG2-1:0] a);
        return (a >= LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        byte_cnt_d = byte_cnt_q;
        rd_done_d  = rd_done_q;
        case (state_q)
            // A start in DONE behaves exactly like one from IDLE; the start
            // address is captured here so later ram_addr changes are ignored.
            IDLE, DONE: begin
                if (bus.strt_rd) begin
                    rd_addr_d  = next_addr(bus.ram_addr);
                    byte_cnt_d = '0;
                    rd_done_d  = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH:   state_d = LAT;
            LAT:     state_d = PRESENT;
            // rd_addr is held here so the RAM output stays stable until the
            // byte has been sent.
            PRESENT: begin
                if (bus.resp_sent) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q + 1'b1 == CNT_FULL) begin
                        rd_done_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        rd_addr_d = next_addr(rd_addr_q);
                        state_d   = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            byte_cnt_q <= '0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            byte_cnt_q <= byte_cnt_d;
            rd_done_q  <= rd_done_d;
        end
    end

    // Strobes decoded straight from the registered state.
    assign bus.rd_en    = (state_q == FETCH);
    assign bus.data_vld = (state_q == PRESENT);
    assign bus.busy     = (state_q == FETCH) || (state_q == LAT) || (state_q == PRESENT);
    assign bus.rd_done  = rd_done_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_dump_rd_ctrl.sv
module tb_dump_rd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dump_rd_ctrl_if #(.LOG2(9)) if0 ();
    dump_rd_ctrl_if #(.LOG2(2)) if1 ();

    dump_rd_ctrl #(.ENTRIES(384), .LOG2(9)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    dump_rd_ctrl #(.ENTRIES(4),   .LOG2(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- access helpers ----------------
    task automatic drive(input int i, input bit s, input bit r, input int ra);
        if (i == 0) begin
            if0.strt_rd = s; if0.resp_sent = r; if0.ram_addr = 9'(ra);
        end else begin
            if1.strt_rd = s; if1.resp_sent = r; if1.ram_addr = 2'(ra);
        end
    endtask

    task automatic get_in(input int i, output bit s, output bit r, output int ra);
        if (i == 0) begin s = if0.strt_rd; r = if0.resp_sent; ra = int'(if0.ram_addr); end
        else        begin s = if1.strt_rd; r = if1.resp_sent; ra = int'(if1.ram_addr); end
    endtask

    task automatic get_outs(input int i, output int addr, output int en, output int vld,
                            output int done, output int bsy, output int cnt);
        if (i == 0) begin
            addr = int'(if0.rd_addr); en = int'(if0.rd_en); vld = int'(if0.data_vld);
            done = int'(if0.rd_done); bsy = int'(if0.busy); cnt = int'(if0.byte_cnt);
        end else begin
            addr = int'(if1.rd_addr); en = int'(if1.rd_en); vld = int'(if1.data_vld);
            done = int'(if1.rd_done); bsy = int'(if1.busy); cnt = int'(if1.byte_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // A dump is described by its base address, the number of bytes sent (k)
    // and the cycle in which the current byte was fetched. Cycle n is the
    // interval following the n-th rising edge.
    int m_E [2] = '{384, 4};
    bit m_act[2], m_done[2], m_started[2];
    int m_k[2], m_base[2], m_fetch[2];
    int cyc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_done[i] = 0; m_started[i] = 0; m_k[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit s, r;
                int ra;
                get_in(i, s, r, ra);
                if (m_act[i]) begin
                    // a byte is on the bus from two cycles after its fetch
                    if (r && (cyc - 1 >= m_fetch[i] + 2)) begin
                        m_k[i]++;
                        if (m_k[i] == m_E[i]) begin
                            m_act[i]  = 0;
                            m_done[i] = 1;
                        end else begin
                            m_fetch[i] = cyc;
                        end
                    end
                end else if (s) begin
                    m_act[i]     = 1;
                    m_done[i]    = 0;
                    m_started[i] = 1;
                    m_k[i]       = 0;
                    m_base[i]    = (ra >= m_E[i] - 1) ? 0 : ra + 1;
                    m_fetch[i]   = cyc;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int addr, en, vld, done, bsy, cnt, e_addr;
            get_outs(i, addr, en, vld, done, bsy, cnt);
            e_addr = m_started[i] ?
                     (m_base[i] + ((m_k[i] < m_E[i]) ? m_k[i] : m_E[i] - 1)) % m_E[i] : 0;
            chk($sformatf("rd_en[%0d]", i),    en,   int'(m_act[i] && cyc == m_fetch[i]));
            chk($sformatf("data_vld[%0d]", i), vld,  int'(m_act[i] && cyc >= m_fetch[i] + 2));
            chk($sformatf("busy[%0d]", i),     bsy,  int'(m_act[i]));
            chk($sformatf("rd_done[%0d]", i),  done, int'(m_done[i]));
            chk($sformatf("byte_cnt[%0d]", i), cnt,  m_k[i]);
            chk($sformatf("rd_addr[%0d]", i),  addr, e_addr);
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: resp_sent three cycles after each data_vld rise.
    // mode 1: random resp_sent every cycle (also outside PRESENT), random
    //         strt_rd while busy and a wandering ram_addr.
    task automatic run_dump(input int i, input int mode, input int stop);
        int cd = 0;
        int prev = 0;
        int limit = m_E[i] * 12 + 50;
        int amax = (i == 0) ? 511 : 3;
        bit ok = 0;
        bit s, r;
        int ra, addr, en, vld, done, bsy, cnt;
        for (int n = 0; n < limit; n++) begin
            get_outs(i, addr, en, vld, done, bsy, cnt);
            if (done != 0 || cnt >= stop) begin
                ok = 1;
                break;
            end
            get_in(i, s, r, ra);
            if (mode == 0) begin
                s = 0;
                if (vld != 0 && prev == 0) begin cd = 3; r = 0; end
                else if (cd > 0) begin cd--; r = (cd == 0); end
                else r = 0;
            end else begin
                r  = ($urandom % 2) == 1;
                s  = (bsy != 0) && !r && (($urandom % 6) == 0);
                ra = $urandom_range(0, amax);
            end
            prev = vld;
            drive(i, s, r, ra);
            step();
        end
        get_in(i, s, r, ra);
        drive(i, 0, 0, ra);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL dump_timeout[%0d]: got no completion expected completion within %0d cycles", i, limit);
        end
    endtask

    task automatic start(input int i, input int ra);
        drive(i, 1, 0, ra);
        step();
        drive(i, 0, 0, ra);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_addr", int'(if0.rd_addr), 0);
        chk("reset_busy", int'(if0.busy), 0);
        chk("reset_byte_cnt", int'(if0.byte_cnt), 0);
        rst = 1'b0;
        step();

        // small RAM: addresses 3,0,1,2 then restart from DONE
        start(1, 2);
        chk("e4_first_addr", int'(if1.rd_addr), 3);
        chk("e4_first_rd_en", int'(if1.rd_en), 1);
        run_dump(1, 0, 99);
        chk("e4_done", int'(if1.rd_done), 1);
        chk("e4_cnt", int'(if1.byte_cnt), 4);
        chk("e4_last_addr", int'(if1.rd_addr), 2);
        start(1, 1);
        chk("e4_restart_done_clr", int'(if1.rd_done), 0);
        chk("e4_restart_addr", int'(if1.rd_addr), 2);
        run_dump(1, 1, 99);
        repeat (20) begin
            start(1, $urandom_range(0, 3));
            run_dump(1, 1, 99);
        end

        // full dump from ram_addr=5
        start(0, 5);
        chk("d1_first_addr", int'(if0.rd_addr), 6);
        run_dump(0, 0, 999);
        chk("d1_cnt", int'(if0.byte_cnt), 384);
        chk("d1_done", int'(if0.rd_done), 1);
        chk("d1_last_addr", int'(if0.rd_addr), 5);

        // ram_addr at the top: start wraps to 0
        start(0, 383);
        chk("d2_first_addr", int'(if0.rd_addr), 0);
        chk("d2_done_clr", int'(if0.rd_done), 0);
        run_dump(0, 1, 999);
        chk("d2_last_addr", int'(if0.rd_addr), 383);

        // second strt_rd two cycles later is ignored
        start(0, 100);
        step();
        drive(0, 1, 0, 7);
        step();
        drive(0, 0, 0, 7);
        chk("d3_rd_en_once", int'(if0.rd_en), 0);
        chk("d3_addr_kept", int'(if0.rd_addr), 101);
        chk("d3_data_vld", int'(if0.data_vld), 1);

        // reset after 10 bytes
        run_dump(0, 1, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_addr", int'(if0.rd_addr), 0);
        chk("rst_mid_cnt", int'(if0.byte_cnt), 0);
        chk("rst_mid_busy", int'(if0.busy), 0);
        chk("rst_mid_vld", int'(if0.data_vld), 0);
        chk("rst_mid_done", int'(if0.rd_done), 0);
        step();
        rst = 1'b0;
        step();
        repeat (3) begin
            start(0, $urandom_range(0, 511));
            run_dump(0, 1, 999);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
